// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter and related schedulers.
package rr_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Index width for n requesters; a single-bit index is kept even when n <= 2.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rot_add(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotating-priority picker: returns the first set bit of req_i
// scanning ptr_i, ptr_i+1, ... and wrapping from N-1 back to 0.
module rr_prio_pick
  import rr_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand     = rot_add(32'(ptr_i), 32'(i), 32'(N));
      cand_idx = IDX_W'(cand);
      if (!found_o && req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/rr_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one valid/ready channel among NUM_PORTS requesters.
// Define RR_PKT_ARB_WEIGHT_EN to add the weight_i port (per-port packets per turn).
module rr_pkt_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int WEIGHT_W  = 4,
  localparam int IDX_W    = idx_width(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_valid_i,
  input  logic [NUM_PORTS-1:0]        req_last_i,
  input  logic [NUM_PORTS*DATA_W-1:0] req_data_i,
  output logic [NUM_PORTS-1:0]        req_ready_o,
`ifdef RR_PKT_ARB_WEIGHT_EN
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight_i,
`endif
  output logic                        out_valid_o,
  output logic                        out_last_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic [IDX_W-1:0]            out_port_o,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic                        busy_o
);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         sel_q, sel_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [NUM_PORTS-1:0]     gnt_q, gnt_d;
  logic [WEIGHT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_PORTS*WEIGHT_W-1:0] weight;
  logic [WEIGHT_W-1:0]      sel_weight;
  logic [WEIGHT_W:0]        cnt_inc, weight_eff;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pkt_done;

  // An all-zero weight means one packet per turn, i.e. plain round robin.
`ifdef RR_PKT_ARB_WEIGHT_EN
  assign weight = weight_i;
`else
  assign weight = '0;
`endif

  rr_prio_pick #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign sel_weight = weight[sel_q*WEIGHT_W +: WEIGHT_W];
  assign weight_eff = (sel_weight == '0) ? (WEIGHT_W+1)'(1) : {1'b0, sel_weight};
  assign cnt_inc    = {1'b0, cnt_q} + (WEIGHT_W+1)'(1);
  assign pkt_done   = req_valid_i[sel_q] & out_ready_i & req_last_i[sel_q];
  assign gnt_o      = gnt_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    out_data_o  = '0;
    out_port_o  = '0;
    req_ready_o = '0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          gnt_d   = NUM_PORTS'(1) << pick_idx;
          state_d = LOCKED;
          // A winner other than the priority holder starts a fresh turn.
          if (pick_idx != ptr_q) cnt_d = '0;
        end
      end
      LOCKED: begin
        busy_o      = 1'b1;
        out_valid_o = req_valid_i[sel_q];
        out_last_o  = req_last_i[sel_q];
        out_data_o  = req_data_i[sel_q*DATA_W +: DATA_W];
        out_port_o  = sel_q;
        req_ready_o = NUM_PORTS'(out_ready_i) << sel_q;
        if (pkt_done) begin
          gnt_d   = '0;
          state_d = IDLE;
          if (cnt_inc >= weight_eff) begin
            ptr_d = IDX_W'(rot_add(32'(sel_q), 32'd1, 32'(NUM_PORTS)));
            cnt_d = '0;
          end else begin
            ptr_d = sel_q;
            cnt_d = cnt_inc[WEIGHT_W-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Self-checking bench for rr_pkt_arbiter: vector table, directed corner sequences,
// and randomized traffic against a packet-level reference model.
module tb_rr_pkt_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid_i, req_last_i, req_ready_o, gnt_o;
  logic [N*DW-1:0] req_data_i;
  logic            out_valid_o, out_last_o, out_ready_i, busy_o;
  logic [DW-1:0]   out_data_o;
  logic [1:0]      out_port_o;
`ifdef RR_PKT_ARB_WEIGHT_EN
  logic [N*4-1:0]  weight_i;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_pkt_arbiter #(.NUM_PORTS(N), .DATA_W(DW), .WEIGHT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_last_i  (req_last_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
`ifdef RR_PKT_ARB_WEIGHT_EN
    .weight_i    (weight_i),
`endif
    .out_valid_o (out_valid_o),
    .out_last_o  (out_last_o),
    .out_data_o  (out_data_o),
    .out_port_o  (out_port_o),
    .out_ready_i (out_ready_i),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       rdy;
    logic [3:0] gnt;
    logic       busy;
    logic       oval;
    logic       olast;
    logic [1:0] port;
    logic [3:0] rready;
  } vec_t;

  function automatic logic [31:0] pdata(input int k);
    return 32'hD000_0000 + 32'(k) * 32'h0000_0111;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [3:0] v, input logic [3:0] l, input logic r);
    req_valid_i = v;
    req_last_i  = l;
    out_ready_i = r;
    #1;
  endtask

  task automatic set_fixed_data();
    for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = pdata(k);
  endtask

  task automatic chk_all(input string nm, input logic [3:0] gnt, input logic busy,
                         input logic oval, input logic olast, input logic [1:0] port,
                         input logic [3:0] rready);
    chk({nm, ".gnt"},   32'(gnt_o),       32'(gnt));
    chk({nm, ".busy"},  32'(busy_o),      32'(busy));
    chk({nm, ".oval"},  32'(out_valid_o), 32'(oval));
    chk({nm, ".port"},  32'(out_port_o),  32'(port));
    chk({nm, ".ready"}, 32'(req_ready_o), 32'(rready));
    if (oval) begin
      chk({nm, ".last"}, 32'(out_last_o), 32'(olast));
      chk({nm, ".data"}, out_data_o, pdata(int'(port)));
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    apply(4'b0, 4'b0, 1'b0);
    edge_();
    edge_();
    reset_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[16];
    int   acc_cnt;
    int unsigned left[N], beat[N], pkt[N];
    bit   on[N];
    bit   m_busy, acc, found;
    int   m_sel, m_ptr, acc_p, idx;
    logic [3:0] v, l, exp_gnt, exp_rdy;
    logic r;

    // Four ports, 2-beat packets, ready held high: order 0,1,2,3,0 with one bubble each.
    tbl[0]  = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[1]  = '{4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1};
    tbl[2]  = '{4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[3]  = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[4]  = '{4'hF, 4'h0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b0, 2'd1, 4'h2};
    tbl[5]  = '{4'hF, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 2'd1, 4'h2};
    tbl[6]  = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[7]  = '{4'hF, 4'h0, 1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 2'd2, 4'h4};
    tbl[8]  = '{4'hF, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, 1'b1, 2'd2, 4'h4};
    tbl[9]  = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[10] = '{4'hF, 4'h0, 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 2'd3, 4'h8};
    tbl[11] = '{4'hF, 4'h8, 1'b1, 4'h8, 1'b1, 1'b1, 1'b1, 2'd3, 4'h8};
    tbl[12] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};
    tbl[13] = '{4'hF, 4'h0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 2'd0, 4'h1};
    tbl[14] = '{4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[15] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0};

`ifdef RR_PKT_ARB_WEIGHT_EN
    weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
`endif
    set_fixed_data();
    reset_dut();
    chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0);

    for (int i = 0; i < 16; i++) begin
      if (i != 0) edge_();
      apply(tbl[i].valid, tbl[i].last, tbl[i].rdy);
      chk_all($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].busy, tbl[i].oval,
              tbl[i].olast, tbl[i].port, tbl[i].rready);
    end

    // Port 2 alone with ptr=3: scan wraps to 2, then ptr lands on 3.
    reset_dut();
    apply(4'b0100, 4'b0100, 1'b1); chk_all("A0", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0100, 4'b0100, 1'b1); chk_all("A1", 4'h4, 1, 1, 1, 2'd2, 4'h4);
    edge_(); apply(4'b0000, 4'b0000, 1'b1); chk_all("A2", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0100, 4'b0000, 1'b1); chk_all("A3", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0100, 4'b0000, 1'b1); chk_all("A4", 4'h4, 1, 1, 0, 2'd2, 4'h4);
    edge_(); apply(4'b0100, 4'b0100, 1'b1); chk_all("A5", 4'h4, 1, 1, 1, 2'd2, 4'h4);
    edge_(); apply(4'b1001, 4'b1001, 1'b1); chk_all("A6", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b1001, 4'b1001, 1'b1); chk_all("A7", 4'h8, 1, 1, 1, 2'd3, 4'h8);
    edge_(); apply(4'b0001, 4'b0001, 1'b1); chk_all("A8", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0001, 4'b0001, 1'b1); chk_all("A9", 4'h1, 1, 1, 1, 2'd0, 4'h1);

    // Port 1 drops valid for 3 cycles mid-packet while 0 and 3 wait.
    edge_(); apply(4'b0010, 4'b0000, 1'b1); chk_all("B0", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0010, 4'b0000, 1'b1); chk_all("B1", 4'h2, 1, 1, 0, 2'd1, 4'h2);
    for (int g = 0; g < 3; g++) begin
      edge_(); apply(4'b1001, 4'b0000, 1'b1);
      chk_all($sformatf("Bgap%0d", g), 4'h2, 1, 0, 0, 2'd1, 4'h2);
    end
    edge_(); apply(4'b1011, 4'b0010, 1'b1); chk_all("B5", 4'h2, 1, 1, 1, 2'd1, 4'h2);
    edge_(); apply(4'b1001, 4'b0000, 1'b1); chk_all("B6", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b1001, 4'b1001, 1'b1); chk_all("B7", 4'h8, 1, 1, 1, 2'd3, 4'h8);
    edge_(); apply(4'b0001, 4'b0001, 1'b1); chk_all("B8", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0001, 4'b0001, 1'b1); chk_all("B9", 4'h1, 1, 1, 1, 2'd0, 4'h1);

    // 3-beat packet on port 0 with out_ready 1,0,1,1.
    acc_cnt = 0;
    edge_(); apply(4'b0001, 4'b0000, 1'b1); chk_all("C0", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b0001, 4'b0000, 1'b1); chk_all("C1", 4'h1, 1, 1, 0, 2'd0, 4'h1);
    if (out_valid_o && out_ready_i) acc_cnt++;
    edge_(); apply(4'b0001, 4'b0000, 1'b0); chk_all("C2", 4'h1, 1, 1, 0, 2'd0, 4'h0);
    if (out_valid_o && out_ready_i) acc_cnt++;
    edge_(); apply(4'b0001, 4'b0000, 1'b1); chk_all("C3", 4'h1, 1, 1, 0, 2'd0, 4'h1);
    if (out_valid_o && out_ready_i) acc_cnt++;
    edge_(); apply(4'b0001, 4'b0001, 1'b1); chk_all("C4", 4'h1, 1, 1, 1, 2'd0, 4'h1);
    if (out_valid_o && out_ready_i) acc_cnt++;
    edge_(); apply(4'b0000, 4'b0000, 1'b1); chk_all("C5", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    chk("C.beats", 32'(acc_cnt), 32'd3);

    // Reset asserted mid-packet on port 3; afterwards ptr is back at 0.
    apply(4'b1000, 4'b0000, 1'b1); chk_all("D0", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b1000, 4'b0000, 1'b0); chk_all("D1", 4'h8, 1, 1, 0, 2'd3, 4'h0);
    edge_(); apply(4'b1000, 4'b0000, 1'b1); chk_all("D2", 4'h8, 1, 1, 0, 2'd3, 4'h8);
    reset_n = 1'b0;
    apply(4'b1000, 4'b0000, 1'b1); chk_all("D3", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b1000, 4'b0000, 1'b1); chk_all("D4", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    reset_n = 1'b1;
    apply(4'b1010, 4'b0000, 1'b1); chk_all("D5", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b1010, 4'b0000, 1'b1); chk_all("D6", 4'h2, 1, 1, 0, 2'd1, 4'h2);
    edge_(); apply(4'b1010, 4'b0010, 1'b1); chk_all("D7", 4'h2, 1, 1, 1, 2'd1, 4'h2);
    edge_(); apply(4'b1000, 4'b1000, 1'b1); chk_all("D8", 4'h0, 0, 0, 0, 2'd0, 4'h0);
    edge_(); apply(4'b1000, 4'b1000, 1'b1); chk_all("D9", 4'h8, 1, 1, 1, 2'd3, 4'h8);

    // Randomized traffic: sources hold each beat until accepted, may pause between beats.
    reset_dut();
    m_busy = 0; m_sel = 0; m_ptr = 0; acc = 0; acc_p = 0;
    for (int p = 0; p < N; p++) begin left[p] = 0; beat[p] = 0; pkt[p] = 0; on[p] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) edge_();
      if (acc) begin
        beat[acc_p]++;
        left[acc_p]--;
        on[acc_p] = 0;
        if (left[acc_p] == 0) pkt[acc_p]++;
      end
      for (int p = 0; p < N; p++) begin
        if (!on[p] && $urandom_range(0, 2) == 0) begin
          if (left[p] == 0) begin
            left[p] = $urandom_range(1, 4);
            beat[p] = 0;
          end
          on[p] = 1;
        end
        v[p] = on[p];
        l[p] = on[p] && (left[p] == 1);
        req_data_i[p*DW +: DW] = {4'(p), 12'(pkt[p]), 16'(beat[p])};
      end
      r = ($urandom_range(0, 3) != 0);
      apply(v, l, r);
      exp_gnt = m_busy ? (4'd1 << m_sel) : 4'd0;
      exp_rdy = (m_busy && r) ? (4'd1 << m_sel) : 4'd0;
      chk("rnd.gnt",   32'(gnt_o),       32'(exp_gnt));
      chk("rnd.busy",  32'(busy_o),      32'(m_busy));
      chk("rnd.oval",  32'(out_valid_o), 32'(m_busy && v[m_sel]));
      chk("rnd.port",  32'(out_port_o),  m_busy ? 32'(m_sel) : 32'd0);
      chk("rnd.ready", 32'(req_ready_o), 32'(exp_rdy));
      if (m_busy && v[m_sel]) begin
        chk("rnd.last", 32'(out_last_o), 32'(l[m_sel]));
        chk("rnd.data", out_data_o, {4'(m_sel), 12'(pkt[m_sel]), 16'(beat[m_sel])});
      end
      acc   = m_busy && v[m_sel] && r;
      acc_p = m_sel;
      if (!m_busy) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && v[idx]) begin
            found  = 1;
            m_sel  = idx;
            m_busy = 1;
          end
        end
      end else if (acc && l[m_sel]) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % N;
      end
    end

`ifdef RR_PKT_ARB_WEIGHT_EN
    begin
      int got[$];
      int exp_order[7];
      exp_order = '{0, 1, 1, 1, 2, 3, 0};
      reset_dut();
      weight_i = {4'd1, 4'd1, 4'd3, 4'd1};
      for (int cyc = 0; cyc < 40 && got.size() < 7; cyc++) begin
        apply(4'b1111, 4'b1111, 1'b1);
        if (out_valid_o && out_ready_i) got.push_back(int'(out_port_o));
        edge_();
      end
      chk("wgt.count", 32'(got.size()), 32'd7);
      for (int i = 0; i < 7 && i < got.size(); i++)
        chk($sformatf("wgt.pkt%0d", i), 32'(got[i]), 32'(exp_order[i]));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_pkt_arbiter.md
Name: rr_pkt_arbiter

Overview:
Packet-level round-robin arbiter that shares one downstream valid/ready channel among NUM_PORTS requesters.
- A granted requester holds the channel until its last beat is accepted; the grant then rotates.
- Beats are muxed combinationally while a grant is held.
- Sits between the per-port request queues and the single shared datapath port.

Parameters:
NUM_PORTS, 4, number of requesters (2..16; any value, not only powers of 2)
DATA_W, 32, payload width per beat
WEIGHT_W, 4, per-port weight field width (used only with the optional feature)

Ports:
clk  input  1  sole clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid_i  input  NUM_PORTS  per-port beat valid
req_last_i  input  NUM_PORTS  per-port last beat of packet
req_data_i  input  NUM_PORTS*DATA_W  per-port payload; port k at bits [k*DATA_W +: DATA_W]
req_ready_o  output  NUM_PORTS  per-port beat accept
out_valid_o  output  1  shared channel valid
out_last_o  output  1  shared channel last
out_data_o  output  DATA_W  shared channel payload
out_port_o  output  $clog2(NUM_PORTS) (min 1)  index of the owning port
out_ready_i  input  1  downstream accept
gnt_o  output  NUM_PORTS  registered one-hot grant; zero when idle
busy_o  output  1  high while a grant is held

Behaviour:
Reset values (async, while reset_n=0):
- gnt_o=0, busy_o=0, out_valid_o=0, req_ready_o=0.
- Rotating pointer ptr=0; state=IDLE.
- Reset mid-packet abandons the packet; no beat is accepted in the reset cycle.

FSM: IDLE, LOCKED.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit scanning ptr, ptr+1, ..., wrapping N-1 -> 0.
  - Register sel <= picked index, gnt_o <= onehot(sel), state <= LOCKED.
  - Arbitration latency: 1 cycle from valid to grant.
  - No requests: stay in IDLE; outputs stay at reset values.
- LOCKED:
  - out_valid_o=req_valid_i[sel]; out_last_o=req_last_i[sel]; out_data_o=slice sel; out_port_o=sel.
  - req_ready_o[sel]=out_ready_i; all other ready bits are 0.
  - Beat accepted when out_valid_o & out_ready_i.
  - Accepted beat with out_last_o=1: ptr <= (sel+1) mod NUM_PORTS, gnt_o <= 0, state <= IDLE.
  - This leaves exactly one bubble cycle between packets.
  - Grant is held when req_valid_i[sel] drops mid-packet. No re-arbitration and no timeout.
- Protocol:
  - Requesters must not drop valid, or change data/last, before the beat is accepted.
  - Downstream may toggle out_ready_i freely.
- Boundaries:
  - Single active requester is re-granted every other cycle after each packet.
  - Single-beat packet: grant lasts 1 cycle if out_ready_i=1.
  - All ports requesting: strict order 0,1,2,...,N-1,0.
  - ptr wraps from N-1 to 0 for non-power-of-2 N.
  - out_port_o holds sel while busy and is 0 when idle.

Optional Feature:
Macro RR_PKT_ARB_WEIGHT_EN adds input weight_i (NUM_PORTS*WEIGHT_W).
- With the macro:
  - A per-grant counter counts completed packets.
  - ptr advances only when count+1 >= weight_i[sel] (weight 0 treated as 1); otherwise ptr stays at sel.
  - sel therefore keeps top priority in the next IDLE cycle.
  - If sel is no longer requesting in IDLE, the scan proceeds normally, ptr advances past the winner, and the counter clears.
  - Counter clears whenever ptr changes and on reset.
- Without the macro: no weight_i port; ptr advances after every packet.

Decomposition:
- Package rr_arb_pkg:
  - state enum (IDLE, LOCKED)
  - localparam function for index width (clog2 with minimum 1)
  - rotate-mod helper function
- Sub-module rr_prio_pick: combinational rotating-priority picker.
  - Inputs: req vector, ptr.
  - Outputs: found flag, index.
  - Reused by future schedulers.

Test Plan:
- All four ports valid, 2-beat packets each, out_ready_i=1 -> grant order 0,1,2,3,0; gnt_o one-hot; one idle cycle between packets.
- Port 2 only, ptr=3 -> scan wraps, grant 2 the cycle after valid; ptr becomes 3 after last; out_port_o=2 throughout.
- Port 1 holds grant mid-packet, valid dropped 3 cycles, ports 0/3 valid -> no grant change; out_valid_o=0 during the gap; packet resumes on port 1.
- out_ready_i toggled 1,0,1 on a 3-beat packet from port 0 -> req_ready_o[0] mirrors it; exactly 3 beats accepted; last on the 3rd accepted beat.
- reset_n asserted mid-packet on port 3 -> gnt_o, busy_o, out_valid_o clear immediately; after release with ports 1 and 3 valid, port 1 granted first (ptr=0).
- RR_PKT_ARB_WEIGHT_EN, weights {1,3,1,1}, all valid -> packet order 0,1,1,1,2,3,0.
